// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and the hex-to-segment decode.
package seg7_pkg;

    // All segments off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {a,b,c,d,e,f,g} patterns, indexed by nibble value (entry 15 first).
    localparam logic [15:0][6:0] HEX_TABLE = {
        7'h38,  // F
        7'h30,  // E
        7'h42,  // d
        7'h31,  // C
        7'h60,  // b
        7'h08,  // A
        7'h04,  // 9
        7'h00,  // 8
        7'h0F,  // 7
        7'h20,  // 6
        7'h24,  // 5
        7'h4C,  // 4
        7'h06,  // 3
        7'h12,  // 2
        7'h4F,  // 1
        7'h01   // 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low segment pattern.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    // Table lookup only; the caller registers the result.
    always_comb begin
        seg_c = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seven_seg_mux_driver.sv
// Multiplexed common-anode seven-segment driver with PWM brightness,
// dead time, per-digit dp/blank and frame-synchronous double buffering.
module seven_seg_mux_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned BRIGHT_W   = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [BRIGHT_W-1:0]     bright_in,
    input  logic                    load,
    output logic                    pending,
    output logic                    frame_tick,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int unsigned CYC_W = $clog2(TICK_DIV);
    localparam int unsigned DIG_W = $clog2(NUM_DIGITS);
    localparam logic [BRIGHT_W-1:0] PH_MAX = '1;

    logic [CYC_W-1:0]        cyc;
    logic [BRIGHT_W-1:0]     ph;
    logic [DIG_W-1:0]        dig;

    logic [4*NUM_DIGITS-1:0] data_s, data_q;
    logic [NUM_DIGITS-1:0]   dp_s, dp_q;
    logic [NUM_DIGITS-1:0]   blank_s, blank_q;
    logic [BRIGHT_W-1:0]     bright_s, bright_q;

    logic                    cyc_end_c, slot_end_c, frame_end_c, active_c;
    logic [3:0]              nib_c;
    logic                    dp_sel_c, blank_sel_c;
    logic [6:0]              dec_seg_c;
    logic [NUM_DIGITS-1:0]   an_next_c;

    assign cyc_end_c   = (cyc == CYC_W'(TICK_DIV - 1));
    assign slot_end_c  = cyc_end_c && (ph == PH_MAX);
    assign frame_end_c = slot_end_c && (dig == DIG_W'(NUM_DIGITS - 1));

    // Scan counters: cycle-in-phase, phase-in-slot, digit index.
    always_ff @(posedge clock) begin
        if (reset) begin
            cyc <= '0;
            ph  <= '0;
            dig <= '0;
        end else if (cyc_end_c) begin
            cyc <= '0;
            if (ph == PH_MAX) begin
                ph  <= '0;
                dig <= frame_end_c ? '0 : dig + DIG_W'(1);
            end else begin
                ph <= ph + BRIGHT_W'(1);
            end
        end else begin
            cyc <= cyc + CYC_W'(1);
        end
    end

    // Shadow capture on load; commit to display only at the frame boundary.
    // The commit reads the pre-load shadow, so a load in the boundary cycle stays pending.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_s     <= '0;
            dp_s       <= '0;
            blank_s    <= '0;
            bright_s   <= '0;
            data_q     <= '0;
            dp_q       <= '0;
            blank_q    <= '1;
            bright_q   <= '1;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end_c;
            if (frame_end_c && pending) begin
                data_q   <= data_s;
                dp_q     <= dp_s;
                blank_q  <= blank_s;
                bright_q <= bright_s;
            end
            if (load) begin
                data_s   <= data_in;
                dp_s     <= dp_in;
                blank_s  <= blank_in;
                bright_s <= bright_in;
                pending  <= 1'b1;
            end else if (frame_end_c) begin
                pending <= 1'b0;
            end
        end
    end

    // Select the scanned digit's nibble, dp and blank flags.
    always_comb begin
        nib_c       = '0;
        dp_sel_c    = 1'b0;
        blank_sel_c = 1'b1;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (dig == DIG_W'(k)) begin
                nib_c       = data_q[4*k +: 4];
                dp_sel_c    = dp_q[k];
                blank_sel_c = blank_q[k];
            end
        end
    end

    // Digit is lit outside the dead-time cycle, within its PWM window, when not blanked.
    always_comb begin
        active_c  = !((cyc == '0) && (ph == '0)) && (ph <= bright_q) && !blank_sel_c;
        an_next_c = '1;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (dig == DIG_W'(k) && active_c) begin
                an_next_c[k] = 1'b0;
            end
        end
    end

    seg7_hex_decoder u_dec (
        .nibble (nib_c),
        .seg_c  (dec_seg_c)
    );

    // Registered pin drivers.
    always_ff @(posedge clock) begin
        if (reset) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_next_c;
            seg <= active_c ? dec_seg_c : SEG_BLANK;
            dp  <= active_c ? !dp_sel_c : 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Randomized and directed bench with a time-position reference model.
module tb_seven_seg_mux_driver;

    localparam int N     = 4;
    localparam int TD    = 2;
    localparam int BW    = 2;
    localparam int S     = TD * (1 << BW);
    localparam int FRAME = N * S;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [4*N-1:0] data_in = '0;
    logic [N-1:0]   dp_in = '0;
    logic [N-1:0]   blank_in = '0;
    logic [BW-1:0]  bright_in = '0;
    logic           load = 1'b0;
    logic           pending, frame_tick, dp;
    logic [N-1:0]   an;
    logic [6:0]     seg;

    seven_seg_mux_driver #(.NUM_DIGITS(N), .TICK_DIV(TD), .BRIGHT_W(BW)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .dp_in(dp_in),
        .blank_in(blank_in), .bright_in(bright_in), .load(load),
        .pending(pending), .frame_tick(frame_tick), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clock = ~clock;

    // Reference segment patterns (active-low abcdefg) for 0..F.
    logic [6:0] ref_seg [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Model state: cycles since reset release, shadow, display and expected pins.
    int             m_t;
    logic [4*N-1:0] sh_data, ds_data;
    logic [N-1:0]   sh_dp, ds_dp, sh_blank, ds_blank;
    logic [BW-1:0]  sh_bright, ds_bright;
    logic           m_pending;
    logic [N-1:0]   e_an;
    logic [6:0]     e_seg;
    logic           e_dp, e_tick;
    int             lit_cycles;

    task automatic model_reset();
        m_t = 0;
        sh_data = '0; sh_dp = '0; sh_blank = '0; sh_bright = '0;
        ds_data = '0; ds_dp = '0; ds_blank = '1; ds_bright = '1;
        m_pending = 1'b0;
        e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
    endtask

    // One clock edge: advance model from the inputs present at the edge, then compare.
    task automatic tick();
        int pos, d, off, phase;
        logic [3:0] nib;
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            pos   = m_t % FRAME;
            d     = pos / S;
            off   = pos % S;
            phase = off / TD;
            nib   = ds_data[4*d +: 4];
            if (off != 0 && phase <= int'(ds_bright) && !ds_blank[d]) begin
                e_an    = '1;
                e_an[d] = 1'b0;
                e_seg   = ref_seg[nib];
                e_dp    = !ds_dp[d];
            end else begin
                e_an = '1; e_seg = 7'h7F; e_dp = 1'b1;
            end
            e_tick = (pos == FRAME - 1);
            if (e_tick && m_pending) begin
                ds_data = sh_data; ds_dp = sh_dp; ds_blank = sh_blank; ds_bright = sh_bright;
                m_pending = 1'b0;
            end
            if (load) begin
                sh_data = data_in; sh_dp = dp_in; sh_blank = blank_in; sh_bright = bright_in;
                m_pending = 1'b1;
            end
            m_t++;
        end
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("pending", 32'(pending), 32'(m_pending));
        check("frame_tick", 32'(frame_tick), 32'(e_tick));
        if (an != '1) lit_cycles++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] p,
                           input logic [N-1:0] b, input logic [BW-1:0] br);
        data_in = d; dp_in = p; blank_in = b; bright_in = br; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        run(n);
        reset = 1'b0;
    endtask

    // Advance until the next edge is the frame boundary.
    task automatic to_boundary();
        for (int i = 0; i < FRAME && (m_t % FRAME) != FRAME - 1; i++) tick();
    endtask

    initial begin
        model_reset();
        lit_cycles = 0;
        do_reset(5);
        check("dark_after_reset", 32'(lit_cycles), 32'd0);

        // Nothing lit before the first load commits.
        run(40);
        check("dark_before_load", 32'(lit_cycles), 32'd0);

        // Basic display: 12AF, dp on digit 0, full brightness.
        do_load(16'h12AF, 4'b0001, 4'b0000, 2'd3);
        run(3 * FRAME);

        // Digit 0 on-time per slot at full brightness is S-1.
        to_boundary();
        tick();
        lit_cycles = 0;
        run(S);
        check("on_time_full", 32'(lit_cycles), 32'(S - 1));

        // Brightness 0 then 1.
        do_load(16'h3456, 4'b0000, 4'b0000, 2'd0);
        run(2 * FRAME);
        to_boundary();
        tick();
        lit_cycles = 0;
        run(S);
        check("on_time_b0", 32'(lit_cycles), 32'(TD - 1));
        do_load(16'h789A, 4'b1010, 4'b0000, 2'd1);
        run(2 * FRAME);
        to_boundary();
        tick();
        lit_cycles = 0;
        run(S);
        check("on_time_b1", 32'(lit_cycles), 32'(2 * TD - 1));

        // Two loads in one frame: only the second is ever committed.
        to_boundary();
        tick();
        do_load(16'h1111, 4'b0000, 4'b0000, 2'd3);
        run(5);
        do_load(16'h8888, 4'b0000, 4'b0000, 2'd3);
        run(2 * FRAME);

        // Load in the boundary cycle stays pending for one more frame.
        do_load(16'hCDEB, 4'b0100, 4'b0000, 2'd2);
        to_boundary();
        do_load(16'h0F0F, 4'b0011, 4'b0000, 2'd3);
        check("pending_after_boundary_load", 32'(pending), 32'd1);
        run(2 * FRAME);

        // Blanking of digits 1 and 3, then a mid-frame reset.
        do_load(16'h4321, 4'b1111, 4'b1010, 2'd3);
        run(FRAME + 10);
        do_reset(1);
        lit_cycles = 0;
        run(2 * FRAME);
        check("dark_after_midframe_reset", 32'(lit_cycles), 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else if ($urandom_range(0, 19) == 0) begin
                do_load(16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                        2'($urandom));
            end else begin
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
